// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Parameterised round-robin arbiter. Grants exactly one of
//            NUM_REQUESTERS requesters per cycle (combinational, one-hot),
//            starting the search at a registered one-hot priority pointer.
//            The pointer advances past the granted requester only when the
//            consumer signals the grant was taken (update_en).
// Ports    : clk        - rising-edge clock
//            reset      - synchronous, active-high; priority -> requester 0
//            req_bitmap - bit i set = requester i requesting this cycle
//            update_en  - grant consumed this cycle; advance priority
//            grant_oh   - one-hot grant, all-zero when no requests
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQUESTERS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQUESTERS-1:0] req_bitmap,
    input  logic                      update_en,
    output logic [NUM_REQUESTERS-1:0] grant_oh
);

    localparam int                      c_DBL_W      = 2 * NUM_REQUESTERS;
    localparam logic [NUM_REQUESTERS-1:0] c_PRIO_RESET = NUM_REQUESTERS'(1);

    logic [NUM_REQUESTERS-1:0] r_priority_oh;
    logic [NUM_REQUESTERS-1:0] w_priority_next;
    logic [c_DBL_W-1:0]        w_req_dbl;
    logic [c_DBL_W-1:0]        w_prio_dbl;
    logic [c_DBL_W-1:0]        w_grant_dbl;

    // Wrap-around search without a loop: the request vector is duplicated so
    // that requesters below the priority position reappear above it. With a
    // one-hot p, x & ~(x - p) isolates the lowest set bit of x at or above p,
    // which is exactly the first requester in round-robin order. Since the
    // upper copy always holds a set bit above p whenever any request exists,
    // the result has a single bit in one of the two halves; OR-ing the halves
    // folds it back to requester numbering. With no requests x = 0 and the
    // result is zero.
    assign w_req_dbl   = {req_bitmap, req_bitmap};
    assign w_prio_dbl  = {{NUM_REQUESTERS{1'b0}}, r_priority_oh};
    assign w_grant_dbl = w_req_dbl & ~(w_req_dbl - w_prio_dbl);

    assign grant_oh = w_grant_dbl[NUM_REQUESTERS-1:0]
                    | w_grant_dbl[c_DBL_W-1:NUM_REQUESTERS];

    // The granted requester becomes lowest priority: next priority is the
    // grant rotated left by one (bit N-1 wraps to bit 0).
    generate
        if (NUM_REQUESTERS > 1) begin : g_rotate_multi
            assign w_priority_next = {grant_oh[NUM_REQUESTERS-2:0],
                                      grant_oh[NUM_REQUESTERS-1]};
        end else begin : g_rotate_single
            assign w_priority_next = grant_oh;
        end
    endgenerate

    // Only a nonzero grant may load the pointer, which keeps it one-hot.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_priority_oh <= c_PRIO_RESET;
        end else if (update_en && (|grant_oh)) begin
            r_priority_oh <= w_priority_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arbiter
// Purpose  : Self-checking bench for rr_arbiter (4 requesters, plus a
//            1-requester instance). Directed scenarios use literal expected
//            grants; the random scenario uses a behavioural model that keeps
//            the priority as an integer index and scans requesters in order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic         upd;
    logic [N-1:0] grant;
    logic         req1;
    logic         grant1;

    int vectors    = 0;
    int miscompares = 0;
    int m_prio     = 0;   // model: index of highest-priority requester

    always #5 clk = ~clk;

    rr_arbiter #(.NUM_REQUESTERS(N)) dut (
        .clk        (clk),
        .reset      (rst),
        .req_bitmap (req),
        .update_en  (upd),
        .grant_oh   (grant)
    );

    rr_arbiter #(.NUM_REQUESTERS(1)) dut1 (
        .clk        (clk),
        .reset      (rst),
        .req_bitmap (req1),
        .update_en  (upd),
        .grant_oh   (grant1)
    );

    // Model: first requesting index scanning p, p+1, ... with wrap; -1 if none.
    function automatic int model_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_grant(input logic [N-1:0] r, input int p);
        int idx;
        idx = model_pick(r, p);
        if (idx < 0) return '0;
        return N'(1) << idx;
    endfunction

    // Apply inputs (just after a rising edge) and move to the sampling point.
    task automatic drive(input logic [N-1:0] r, input logic u, input logic rs);
        req  = r;
        upd  = u;
        rst  = rs;
        req1 = r[0];
        @(negedge clk);
    endtask

    // Cross the rising edge and update the model from pre-edge inputs.
    task automatic advance();
        int idx;
        idx = model_pick(req, m_prio);
        @(posedge clk);
        if (rst)                  m_prio = 0;
        else if (upd && idx >= 0) m_prio = (idx + 1) % N;
        #1;
    endtask

    task automatic test_reset();
        drive(4'b0000, 1'b1, 1'b1);
        advance();
        drive(4'b1111, 1'b0, 1'b0);
        vectors++;
        if (grant !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_prio: grant=%b expected=%b", grant, 4'b0001);
        end
        advance();
        drive(4'b0000, 1'b1, 1'b0);
        vectors++;
        if (grant !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_noreq: grant=%b expected=%b", grant, 4'b0000);
        end
        advance();
        drive(4'b1111, 1'b0, 1'b0);
        vectors++;
        if (grant !== 4'b0001) begin
            miscompares++;
            $display("FAIL noreq_update_held: grant=%b expected=%b", grant, 4'b0001);
        end
        advance();
    endtask

    task automatic test_rotate();
        logic [N-1:0] exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 5; i++) begin
            drive(4'b1111, 1'b1, 1'b0);
            vectors++;
            if (grant !== exp[i]) begin
                miscompares++;
                $display("FAIL rotate[%0d]: grant=%b expected=%b", i, grant, exp[i]);
            end
            advance();
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 4; i++) begin
            drive(4'b1111, 1'b0, 1'b0);
            vectors++;
            if (grant !== 4'b0010) begin
                miscompares++;
                $display("FAIL hold[%0d]: grant=%b expected=%b", i, grant, 4'b0010);
            end
            advance();
        end
    endtask

    task automatic test_skip();
        logic [N-1:0] exp [4] = '{4'b0100, 4'b0001, 4'b0100, 4'b0001};
        for (int i = 0; i < 4; i++) begin
            drive(4'b0101, 1'b1, 1'b0);
            vectors++;
            if (grant !== exp[i]) begin
                miscompares++;
                $display("FAIL skip[%0d]: grant=%b expected=%b", i, grant, exp[i]);
            end
            advance();
        end
    endtask

    task automatic test_sparse();
        logic [N-1:0] exp [3] = '{4'b0010, 4'b1000, 4'b0010};
        for (int i = 0; i < 3; i++) begin
            drive(4'b1010, 1'b1, 1'b0);
            vectors++;
            if (grant !== exp[i]) begin
                miscompares++;
                $display("FAIL sparse[%0d]: grant=%b expected=%b", i, grant, exp[i]);
            end
            advance();
        end
        for (int i = 0; i < 3; i++) begin
            drive(4'b0100, 1'b1, 1'b0);
            vectors++;
            if (grant !== 4'b0100) begin
                miscompares++;
                $display("FAIL single_req[%0d]: grant=%b expected=%b", i, grant, 4'b0100);
            end
            advance();
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 3; i++) begin
            drive(4'b0000, 1'b1, 1'b0);
            vectors++;
            if (grant !== 4'b0000) begin
                miscompares++;
                $display("FAIL idle[%0d]: grant=%b expected=%b", i, grant, 4'b0000);
            end
            advance();
        end
        drive(4'b1111, 1'b0, 1'b0);
        vectors++;
        if (grant !== 4'b1000) begin
            miscompares++;
            $display("FAIL idle_restore: grant=%b expected=%b", grant, 4'b1000);
        end
        advance();
    endtask

    task automatic test_reset_mid();
        drive(4'b0000, 1'b0, 1'b1);
        advance();
        drive(4'b1111, 1'b1, 1'b0);
        advance();
        drive(4'b1111, 1'b1, 1'b0);
        advance();
        drive(4'b1111, 1'b0, 1'b0);
        vectors++;
        if (grant !== 4'b0100) begin
            miscompares++;
            $display("FAIL mid_pre: grant=%b expected=%b", grant, 4'b0100);
        end
        advance();
        drive(4'b1111, 1'b1, 1'b1);
        vectors++;
        if (grant !== 4'b0100) begin
            miscompares++;
            $display("FAIL mid_during: grant=%b expected=%b", grant, 4'b0100);
        end
        advance();
        drive(4'b1111, 1'b1, 1'b0);
        vectors++;
        if (grant !== 4'b0001) begin
            miscompares++;
            $display("FAIL mid_after: grant=%b expected=%b", grant, 4'b0001);
        end
        advance();
    endtask

    task automatic test_random();
        logic [N-1:0] exp;
        for (int i = 0; i < 400; i++) begin
            drive(N'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
            exp = model_grant(req, m_prio);
            vectors++;
            if (grant !== exp) begin
                miscompares++;
                $display("FAIL random[%0d]: req=%b upd=%b rst=%b grant=%b expected=%b",
                         i, req, upd, rst, grant, exp);
            end
            vectors++;
            if (grant1 !== req1) begin
                miscompares++;
                $display("FAIL n1_random[%0d]: grant=%b expected=%b", i, grant1, req1);
            end
            advance();
        end
    endtask

    initial begin
        rst  = 1'b1;
        req  = '0;
        upd  = 1'b0;
        req1 = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_rotate();
        test_hold();
        test_skip();
        test_sparse();
        test_idle();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
